// File: rtl/cla_seq_adder.sv
// cla_seq_adder: two-requester multi-precision adder built around a single
// 4-bit carry-lookahead slice, processing one nibble per cycle LSB first.
//
// Optional feature macro: CLA_SEQ_SUB_EN (honour reqX_sub as subtract).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid / reqN_ready         per-requester operation handshake
//   reqN_a, reqN_b, reqN_sub        per-requester operands and subtract select
//   res_valid / res_ready           result handshake
//   res_sum, res_cout, res_id       result, carry out (no-borrow when subtracting), requester id
//   busy                            high whenever not idle
module cla_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               id_q, id_d;

    logic               grant;
    logic               accept;
    logic               sel_sub;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [3:0]         nib_p, nib_g, nib_s;
    logic [4:0]         nib_c;

    // Round-robin grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign sel_a = grant ? req1_a : req0_a;

`ifdef CLA_SEQ_SUB_EN
    // Subtract as a + ~b + 1: invert b at capture, carry-in of 1.
    assign sel_sub = grant ? req1_sub : req0_sub;
    assign sel_b   = sel_sub ? ~(grant ? req1_b : req0_b) : (grant ? req1_b : req0_b);
`else
    logic unused_sub;
    assign unused_sub = req0_sub ^ req1_sub;
    assign sel_sub    = 1'b0;
    assign sel_b      = grant ? req1_b : req0_b;
`endif

    // 4-bit carry-lookahead slice on the low nibble of the operand shifters.
    always_comb begin
        nib_p    = a_q[3:0] ^ b_q[3:0];
        nib_g    = a_q[3:0] & b_q[3:0];
        nib_c[0] = carry_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_s    = nib_p ^ nib_c[3:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADD;
            ST_ADD:  if (cnt_q == CNT_W'(NIB - 1)) state_d = ST_DONE;
            ST_DONE: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; ready is gated by reset so neither requester sees it while held in reset.
    always_comb begin
        req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !grant;
        req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid && grant;
        res_valid  = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        res_sum    = sum_q;
        res_cout   = carry_q;
        res_id     = id_q;
    end

    assign accept = req0_ready | req1_ready;

    // Datapath: capture on accept, then shift one nibble per ADD cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    carry_d = sel_sub;
                    cnt_d   = '0;
                    last_d  = grant;
                    id_d    = grant;
                end
            end
            ST_ADD: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                sum_d   = {nib_s, sum_q[WIDTH-1:4]};
                carry_d = nib_c[4];
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: expected results are pushed on accept
// and checked by a negedge monitor against a plain-arithmetic reference.
module tb_cla_seq_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;
`ifdef CLA_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_id, busy;
    logic [W-1:0] res_sum;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cnt[2] = '{0, 0};
    int   acc_tot = 0;
    int   acc_cyc_last = 0;
    int   acc_cyc_q[$];
    int   acc_id_q[$];
    logic last_m = 1'b1;
    logic inflight = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic; subtract carry means no borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic id);
        exp_t       r;
        logic [W:0] wide;
        if (sub && SUB_EN) begin
            r.sum  = a - b;
            r.cout = (a >= b);
        end else begin
            wide   = {1'b0, a} + {1'b0, b};
            r.sum  = wide[W-1:0];
            r.cout = wide[W];
        end
        r.id = id;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        int k = $urandom_range(0, 7);
        if (k == 0) return '1;
        if (k == 1) return '0;
        return W'($urandom);
    endfunction

    task automatic note_acc(input int r);
        acc_cnt[r]++;
        acc_tot++;
        acc_cyc_last = cyc;
        acc_cyc_q.push_back(cyc);
        acc_id_q.push_back(r);
        last_m   = 1'(r);
        inflight = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: arbitration model, accept capture, result scoreboard.
    always @(negedge clk) begin
        logic e0, e1;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            inflight = 1'b0;
            last_m   = 1'b1;
        end else begin
            e0 = !inflight && req0_valid && (!req1_valid || last_m);
            e1 = !inflight && req1_valid && (!req0_valid || !last_m);
            check("req0_ready", 32'(req0_ready), 32'(e0));
            check("req1_ready", 32'(req1_ready), 32'(e1));
            check("busy", 32'(busy), 32'(inflight));
            if (res_valid && !prev_valid)
                check("latency", 32'(cyc - acc_cyc_last), 32'(NIB + 1));
            if (req0_valid && req0_ready) begin
                exp_q.push_back(model(req0_a, req0_b, req0_sub, 1'b0));
                note_acc(0);
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back(model(req1_a, req1_b, req1_sub, 1'b1));
                note_acc(1);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sum 0x%0h with nothing expected", res_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("res_sum", 32'(res_sum), 32'(e.sum));
                    check("res_cout", 32'(res_cout), 32'(e.cout));
                    check("res_id", 32'(res_id), 32'(e.id));
                    inflight = 1'b0;
                end
            end
        end
        prev_valid = res_valid;
    end

    task automatic set_req(input int r, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic s);
        if (r == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
        end
    endtask

    task automatic wait_acc(input int r, input int prev);
        int n = 0;
        while (acc_cnt[r] == prev && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (acc_cnt[r] == prev) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req%0d never accepted", r);
        end
    endtask

    task automatic wait_tot(input int prev);
        int n = 0;
        while (acc_tot == prev && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (acc_tot == prev) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: no request accepted");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || inflight) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0 || inflight) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, p1, n;
        int pc[2];

        // Reset with both requesters already valid.
        rst_n     = 1'b0;
        res_ready = 1'b1;
        set_req(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        set_req(1, 1'b1, 16'h00FF, 16'h0001, 1'b0);
        #2;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_cout", 32'(res_cout), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("first_grant0", 32'(req0_ready), 32'd1);
        check("first_grant1", 32'(req1_ready), 32'd0);

        // Contention from reset: req0 then req1.
        p0 = acc_cnt[0];
        p1 = acc_cnt[1];
        wait_acc(0, p0);
        set_req(0, 1'b0, '0, '0, 1'b0);
        wait_acc(1, p1);
        set_req(1, 1'b0, '0, '0, 1'b0);
        drain();

        // Continuous contention: alternation and issue interval.
        acc_cyc_q.delete();
        acc_id_q.delete();
        set_req(0, 1'b1, rand_op(), rand_op(), 1'b0);
        set_req(1, 1'b1, rand_op(), rand_op(), 1'b0);
        for (int k = 0; k < 4; k++) begin
            int p;
            p = acc_tot;
            wait_tot(p);
            if (k < 3 && acc_id_q.size() > 0)
                set_req(acc_id_q[$], 1'b1, rand_op(), rand_op(), 1'b0);
        end
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        check("rr_count", 32'(acc_id_q.size()), 32'd4);
        if (acc_id_q.size() == 4) begin
            for (int k = 0; k < 4; k++) check("rr_order", 32'(acc_id_q[k]), 32'(k % 2));
            for (int k = 0; k < 3; k++)
                check("issue_interval", 32'(acc_cyc_q[k+1] - acc_cyc_q[k]), 32'(NIB + 2));
        end
        drain();

        // Carry out of the top nibble.
        p0 = acc_cnt[0];
        set_req(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        wait_acc(0, p0);
        set_req(0, 1'b0, '0, '0, 1'b0);
        drain();

        // Back-pressure: DONE held while res_ready is low.
        res_ready = 1'b0;
        p0 = acc_cnt[0];
        p1 = acc_cnt[1];
        set_req(0, 1'b1, rand_op(), rand_op(), 1'b0);
        wait_acc(0, p0);
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_valid", 32'(res_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() > 0) begin
                check("hold_sum", 32'(res_sum), 32'(exp_q[0].sum));
                check("hold_cout", 32'(res_cout), 32'(exp_q[0].cout));
                check("hold_id", 32'(res_id), 32'(exp_q[0].id));
            end
            check("hold_req0_ready", 32'(req0_ready), 32'd0);
            check("hold_req1_ready", 32'(req1_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        wait_acc(1, p1);
        set_req(1, 1'b0, '0, '0, 1'b0);
        drain();

        // Reset during the second ADD cycle after a req0 grant.
        p0 = acc_cnt[0];
        set_req(0, 1'b1, rand_op(), rand_op(), 1'b0);
        wait_acc(0, p0);
        set_req(0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 16'h0F0F, 16'h00F1, 1'b0);
        set_req(1, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_sum", 32'(res_sum), 32'd0);
        check("mid_rst_res_cout", 32'(res_cout), 32'd0);
        check("mid_rst_res_id", 32'(res_id), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        check("mid_rst_req1_ready", 32'(req1_ready), 32'd0);
        p0 = acc_cnt[0];
        p1 = acc_cnt[1];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_grant0", 32'(req0_ready), 32'd1);
        check("post_rst_grant1", 32'(req1_ready), 32'd0);
        wait_acc(0, p0);
        set_req(0, 1'b0, '0, '0, 1'b0);
        wait_acc(1, p1);
        set_req(1, 1'b0, '0, '0, 1'b0);
        drain();

        // Subtract request (honoured only when the feature is built).
        p1 = acc_cnt[1];
        set_req(1, 1'b1, 16'h0005, 16'h0007, 1'b1);
        wait_acc(1, p1);
        set_req(1, 1'b0, '0, '0, 1'b0);
        drain();

        // Randomized traffic with random back-pressure.
        pc[0] = acc_cnt[0];
        pc[1] = acc_cnt[1];
        repeat (400) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (acc_cnt[r] != pc[r]) begin
                    pc[r] = acc_cnt[r];
                    set_req(r, ($urandom_range(0, 2) != 0), rand_op(), rand_op(),
                            1'($urandom_range(0, 1)));
                end else if (!(r == 0 ? req0_valid : req1_valid) && $urandom_range(0, 1) == 1) begin
                    set_req(r, 1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        res_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Sequenced multi-precision adder that shares one 4-bit carry-lookahead slice between two requesters. Each accepted operation is processed one nibble per cycle, LSB nibble first, with the carry registered between nibbles. A round-robin arbiter grants one requester at a time, and results leave on a valid/ready port tagged with the requester ID. The block sits between the two operand producers and a single result consumer.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8; NIB = WIDTH/4
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_sub  in  1  requester 0 selects subtract (see Configuration)
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same roles for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_sum  out  WIDTH  sum or difference, modulo 2^WIDTH
- res_cout  out  1  carry out of the MSB nibble
- res_id  out  1  requester that issued the result
- busy  out  1  high in every state other than IDLE

## Operation
- States: IDLE, ADD, DONE.
- IDLE: compute the grant. If only one requester is valid, grant it. If both are valid, grant the one not granted last. The last-grant pointer resets to 1, so req0 wins the first contention.
  - reqX_ready = (state==IDLE) && grant==X. It depends combinationally on valid and the pointer; ready is never high for both requesters.
- Accept edge, valid&ready: capture a, b (b inverted if sub is active) and the sub bit. Set carry = sub-active ? 1 : 0, set nibble counter = 0, update the pointer, and go to ADD.
- ADD: per cycle, the internal CLA slice computes p=a^b and g=a&b on the current nibble with the carry-in. Carries use full lookahead form: c1..c4 from g, p and cin.
  - Sum nibble shifts into the result register from the MSB side. Operand registers shift right by 4. The carry register takes c4.
  - Counter increments. When counter==NIB-1, go to DONE.
- DONE: res_valid=1; res_sum, res_cout and res_id stay stable. On res_valid&res_ready, go to IDLE.
- Requesters are not accepted in ADD or DONE. Requests stay pending and operands must be held by the requester until its ready is asserted.
- Arithmetic: res_sum = (a + b) mod 2^WIDTH; res_cout = bit WIDTH of a+b. In subtract mode, res_sum = (a - b) mod 2^WIDTH and res_cout = 1 means no borrow (a >= b unsigned).
- Reset, asynchronous, at any time including mid-ADD: state=IDLE, counter=0, carry=0, pointer=1, result register 0. Any in-flight operation is discarded.

## Timing
- Reset values: req0_ready=0, req1_ready=0 until reset deassertion. Then in IDLE, ready follows the grant logic. res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0.
- Accept at edge E0. ADD occupies edges E0+1..E0+NIB. res_valid is high in the cycle after edge E0+NIB, so latency from accept to res_valid is NIB cycles (4 at WIDTH=16).
- If res_ready is high in the first DONE cycle, state is IDLE after the next edge. The earliest next accept is one cycle later, giving a minimum issue interval of NIB+2 cycles.
- res_ready held low: DONE persists indefinitely, outputs do not change, and no request is accepted.
- A requester deasserting valid in IDLE before acceptance is allowed; no state changes.

## Configuration
- CLA_SEQ_SUB_EN defined: reqX_sub is honoured. b is inverted at capture and carry-in is 1.
- CLA_SEQ_SUB_EN undefined: reqX_sub ports remain but are ignored. Operations are always add with carry-in 0, and no inversion logic is built.

## Test plan
- WIDTH=16, req0: a=0xFFFF, b=0x0001 -> res_valid 4 cycles after accept, res_sum=0x0000, res_cout=1, res_id=0.
- Both valid from reset with a=0x1234/b=0x1111 (req0) and a=0x00FF/b=0x0001 (req1) -> req0 served first with 0x2345, cout=0; then req1 with 0x0100, res_id=1.
- req0 and req1 continuously valid for 4 operations -> grants alternate 0,1,0,1; no requester is starved; issue interval is 6 cycles with res_ready tied high.
- res_ready held low for 5 cycles in DONE -> res_sum, res_cout and res_id stable; both readys stay 0; busy=1.
- rst_n pulsed low during the 2nd ADD cycle -> all outputs return to reset values immediately, and the next contention grants req0.
- With CLA_SEQ_SUB_EN, req1_sub=1, a=0x0005, b=0x0007 -> res_sum=0xFFFE, res_cout=0. Without the macro, the same stimulus -> 0x000C, res_cout=0.
